// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode encodings, the legality
// check used to flag undefined opcodes, and the arbiter FSM state encoding.
package alu_arbiter_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b1000;
   localparam logic [3:0] OP_AND = 4'b0111;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0001;
   localparam logic [3:0] OP_SRL = 4'b0101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_CAPT = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   function automatic logic is_legal_op(input logic [3:0] opcode);
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: is_legal_op = 1'b1;
         default:                                               is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// The arbiter connects through the slave modport; the requester/ALU side uses master.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_operand1;
   logic [NUM_REQ*WIDTH-1:0] req_operand2;
   logic [NUM_REQ*4-1:0]     req_opcode;

   logic [WIDTH-1:0]         alu_operand1;
   logic [WIDTH-1:0]         alu_operand2;
   logic [3:0]               alu_opcode;
   logic [WIDTH:0]           alu_result;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [IDW-1:0]           rsp_id;
   logic [WIDTH:0]           rsp_result;
   logic                     rsp_illegal;

   modport master (
      output req_valid, req_operand1, req_operand2, req_opcode, alu_result, rsp_ready,
      input  req_ready, alu_operand1, alu_operand2, alu_opcode,
             rsp_valid, rsp_id, rsp_result, rsp_illegal
   );

   modport slave (
      input  req_valid, req_operand1, req_operand2, req_opcode, alu_result, rsp_ready,
      output req_ready, alu_operand1, alu_operand2, alu_opcode,
             rsp_valid, rsp_id, rsp_result, rsp_illegal
   );

endinterface

// File: rtl/alu.sv
// Registered ALU with a (WIDTH+1)-bit result; bit WIDTH carries the add carry or
// subtract borrow. Undefined opcodes produce zero.
module alu
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic [WIDTH:0]   result
);
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH:0] result_d;
   logic [WIDTH:0] result_q;
   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] b_ext;

   assign a_ext = {1'b0, operand1};
   assign b_ext = {1'b0, operand2};

   always_comb begin
      result_d = '0;
      case (opcode)
         OP_ADD:  result_d = a_ext + b_ext;
         OP_SUB:  result_d = a_ext - b_ext;
         OP_AND:  result_d = a_ext & b_ext;
         OP_OR:   result_d = a_ext | b_ext;
         OP_XOR:  result_d = a_ext ^ b_ext;
         OP_SLL:  result_d = {1'b0, operand1 << operand2[SHW-1:0]};
         OP_SRL:  result_d = {1'b0, operand1 >> operand2[SHW-1:0]};
         default: result_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      result_q <= result_d;
   end

   assign result = result_q;

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// modulo NUM_REQ. Produces a one-hot grant, its index, and an any-grant flag.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx,
   output logic               any
);

   always_comb begin
      logic [IDW:0]   cand;
      logic [IDW-1:0] sel;
      logic           found;
      logic           hit;
      grant = '0;
      sel   = '0;
      found = 1'b0;
      cand  = '0;
      hit   = 1'b0;
      // Extra bit on cand keeps the wrap correct for non-power-of-two NUM_REQ.
      for (int k = 0; k < NUM_REQ; k++) begin
         cand  = {1'b0, ptr} + (IDW+1)'(k);
         cand  = (cand >= (IDW+1)'(NUM_REQ)) ? cand - (IDW+1)'(NUM_REQ) : cand;
         hit   = req[cand[IDW-1:0]] & ~found;
         grant[cand[IDW-1:0]] = hit;
         sel   = hit ? cand[IDW-1:0] : sel;
         found = found | hit;
      end
      idx = sel;
      any = found;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters: round-robin grant, one op
// in flight, result returned tagged with the requester index.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
) (
   input logic          clock,
   input logic          reset,
   alu_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NUM_REQ);

   state_e           state_q,        state_d;
   logic [IDW-1:0]   rr_ptr_q,       rr_ptr_d;
   logic [IDW-1:0]   rsp_id_q,       rsp_id_d;
   logic [WIDTH-1:0] alu_operand1_q, alu_operand1_d;
   logic [WIDTH-1:0] alu_operand2_q, alu_operand2_d;
   logic [3:0]       alu_opcode_q,   alu_opcode_d;
   logic             rsp_valid_q,    rsp_valid_d;
   logic [WIDTH:0]   rsp_result_q,   rsp_result_d;
   logic             rsp_illegal_q,  rsp_illegal_d;

   logic [NUM_REQ-1:0] gnt_onehot;
   logic [IDW-1:0]     gnt_idx;
   logic               gnt_any;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_arbiter (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (gnt_onehot),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      rsp_id_d       = rsp_id_q;
      alu_operand1_d = alu_operand1_q;
      alu_operand2_d = alu_operand2_q;
      alu_opcode_d   = alu_opcode_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_result_d   = rsp_result_q;
      rsp_illegal_d  = rsp_illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               alu_operand1_d = bus.req_operand1[gnt_idx*WIDTH +: WIDTH];
               alu_operand2_d = bus.req_operand2[gnt_idx*WIDTH +: WIDTH];
               alu_opcode_d   = bus.req_opcode[gnt_idx*4 +: 4];
               rsp_id_d       = gnt_idx;
               rr_ptr_d       = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
               state_d        = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         // The ALU registers its result on the edge leaving EXEC.
         ST_EXEC: state_d = ST_CAPT;
         ST_CAPT: begin
            rsp_result_d  = bus.alu_result;
            rsp_illegal_d = ~is_legal_op(alu_opcode_q);
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         rsp_id_q       <= '0;
         alu_operand1_q <= '0;
         alu_operand2_q <= '0;
         alu_opcode_q   <= 4'b0000;
         rsp_valid_q    <= 1'b0;
         rsp_result_q   <= '0;
         rsp_illegal_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         rsp_id_q       <= rsp_id_d;
         alu_operand1_q <= alu_operand1_d;
         alu_operand2_q <= alu_operand2_d;
         alu_opcode_q   <= alu_opcode_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_result_q   <= rsp_result_d;
         rsp_illegal_q  <= rsp_illegal_d;
      end
   end

   assign bus.req_ready    = (state_q == ST_IDLE) ? gnt_onehot : '0;
   assign bus.alu_operand1 = alu_operand1_q;
   assign bus.alu_operand2 = alu_operand2_q;
   assign bus.alu_opcode   = alu_opcode_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_illegal  = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter driving a real alu: directed vectors,
// multi-cycle corner sequences, and randomized traffic against a transaction model.
module tb_alu_arbiter;
   localparam int NR = 4;
   localparam int W  = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

   alu_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   alu #(.WIDTH(W)) u_alu (
      .clock    (clk),
      .opcode   (bus.alu_opcode),
      .operand1 (bus.alu_operand1),
      .operand2 (bus.alu_operand2),
      .result   (bus.alu_result)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int           id;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   res;
      logic         ill;
   } vec_t;

   typedef struct {
      int         id;
      logic [W:0] res;
      logic       ill;
   } rsp_t;

   vec_t vecs[11];
   rsp_t expq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU behaviour written from the opcode table.
   function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W:0] ea;
      logic [W:0] eb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      case (op)
         4'b0000: return ea + eb;
         4'b1000: return ea - eb;
         4'b0111: return ea & eb;
         4'b0110: return ea | eb;
         4'b0100: return ea ^ eb;
         4'b0001: return {1'b0, a << b[4:0]};
         4'b0101: return {1'b0, a >> b[4:0]};
         default: return '0;
      endcase
   endfunction

   function automatic logic ref_illegal(input logic [3:0] op);
      return !(op inside {4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0001, 4'b0101});
   endfunction

   task automatic set_req(input int i, input logic v, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      bus.req_valid[i]            = v;
      bus.req_opcode[i*4 +: 4]    = op;
      bus.req_operand1[i*W +: W]  = a;
      bus.req_operand2[i*W +: W]  = b;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"},   64'(bus.req_ready),    64'd0);
      check({tag, "_rsp_valid"},   64'(bus.rsp_valid),    64'd0);
      check({tag, "_rsp_id"},      64'(bus.rsp_id),       64'd0);
      check({tag, "_rsp_result"},  64'(bus.rsp_result),   64'd0);
      check({tag, "_rsp_illegal"}, 64'(bus.rsp_illegal),  64'd0);
      check({tag, "_alu_op1"},     64'(bus.alu_operand1), 64'd0);
      check({tag, "_alu_op2"},     64'(bus.alu_operand2), 64'd0);
      check({tag, "_alu_opcode"},  64'(bus.alu_opcode),   64'd0);
   endtask

   task automatic clear_inputs();
      bus.req_valid    = '0;
      bus.req_operand1 = '0;
      bus.req_operand2 = '0;
      bus.req_opcode   = '0;
      bus.rsp_ready    = 1'b1;
   endtask

   // Called at a negedge; leaves the bench at a negedge with the DUT idle.
   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Single request from an otherwise idle system; called and returns at a negedge.
   task automatic run_vec(input vec_t v);
      logic [NR-1:0] expg;
      expg = '0;
      expg[v.id] = 1'b1;
      set_req(v.id, 1'b1, v.op, v.a, v.b);
      #1;
      check("vec_grant", 64'(bus.req_ready), 64'(expg));
      @(negedge clk);
      check("vec_exec_ready", 64'(bus.req_ready), 64'd0);
      check("vec_exec_valid", 64'(bus.rsp_valid), 64'd0);
      check("vec_alu_opcode", 64'(bus.alu_opcode), 64'(v.op));
      bus.req_valid[v.id] = 1'b0;
      @(negedge clk);
      check("vec_capt_valid", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      check("vec_rsp_valid",   64'(bus.rsp_valid),   64'd1);
      check("vec_rsp_id",      64'(bus.rsp_id),      64'(v.id));
      check("vec_rsp_result",  64'(bus.rsp_result),  64'(v.res));
      check("vec_rsp_illegal", 64'(bus.rsp_illegal), 64'(v.ill));
      @(negedge clk);
      check("vec_rsp_done", 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      int            last_cyc;
      int            gcount;
      int            exp_seq[5];
      logic [NR-1:0] expg;
      int            mptr;
      bit            mbusy;
      int            mleft;
      int            gi;
      int            gprev;
      int            c;
      int            ngrants;
      logic [3:0]    rop;
      logic [W-1:0]  ra;
      logic [W-1:0]  rb;
      rsp_t          r;

      vecs[0]  = '{0, 4'b0000, 32'd5,          32'd7,          33'd12,             1'b0};
      vecs[1]  = '{0, 4'b1000, 32'd0,          32'd1,          33'h1_FFFF_FFFF,    1'b0};
      vecs[2]  = '{2, 4'b0001, 32'd1,          32'd31,         33'h0_8000_0000,    1'b0};
      vecs[3]  = '{3, 4'b1111, 32'hDEAD_BEEF,  32'h1234_5678,  33'd0,              1'b1};
      vecs[4]  = '{1, 4'b0111, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  33'h0_00F0_00F0,    1'b0};
      vecs[5]  = '{2, 4'b0110, 32'h1234_0000,  32'h0000_5678,  33'h0_1234_5678,    1'b0};
      vecs[6]  = '{3, 4'b0100, 32'hFFFF_0000,  32'h0F0F_0F0F,  33'h0_F0F0_0F0F,    1'b0};
      vecs[7]  = '{1, 4'b0101, 32'h8000_0000,  32'd4,          33'h0_0800_0000,    1'b0};
      vecs[8]  = '{0, 4'b0000, 32'hFFFF_FFFF,  32'd1,          33'h1_0000_0000,    1'b0};
      vecs[9]  = '{1, 4'b0010, 32'd3,          32'd4,          33'd0,              1'b1};
      vecs[10] = '{2, 4'b1000, 32'd5,          32'd3,          33'd2,              1'b0};

      // Reset state.
      clear_inputs();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors.
      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // Round-robin with all requesters valid: 0,1,2,3,0 one every 4 cycles.
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 4'b0000, 32'(i * 10), 32'd1);
      exp_seq  = '{0, 1, 2, 3, 0};
      gcount   = 0;
      last_cyc = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (bus.req_ready != '0) begin
            expg = '0;
            expg[exp_seq[gcount % 5]] = 1'b1;
            check("rr_order", 64'(bus.req_ready), 64'(expg));
            if (gcount > 0) check("rr_spacing", 64'(cyc - last_cyc), 64'd4);
            last_cyc = cyc;
            gcount++;
         end
         if (bus.rsp_valid) begin
            check("rr_rsp_id", 64'(bus.rsp_id), 64'(exp_seq[(gcount - 1) % 5]));
         end
         @(negedge clk);
      end
      check("rr_grant_count", 64'(gcount), 64'd5);
      bus.req_valid = '0;
      repeat (4) @(negedge clk);

      // Response back-pressure: rsp_* hold and no new grant while stalled.
      bus.rsp_ready = 1'b0;
      set_req(1, 1'b1, 4'b0000, 32'd100, 32'd23);
      @(negedge clk);
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      set_req(0, 1'b1, 4'b0100, 32'hAAAA_5555, 32'hFFFF_FFFF);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         check("stall_hold_valid",  64'(bus.rsp_valid),  64'd1);
         check("stall_hold_id",     64'(bus.rsp_id),     64'd1);
         check("stall_hold_result", 64'(bus.rsp_result), 64'd123);
         check("stall_ready_zero",  64'(bus.req_ready),  64'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("stall_released", 64'(bus.rsp_valid), 64'd0);
      check("stall_next_grant", 64'(bus.req_ready), 64'b0001);
      @(negedge clk);
      bus.req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("stall_next_rsp_id",     64'(bus.rsp_id),     64'd0);
      check("stall_next_rsp_result", 64'(bus.rsp_result), 64'h0_5555_AAAA);
      @(negedge clk);

      // Reset during EXEC abandons the op.
      set_req(2, 1'b1, 4'b0000, 32'd1, 32'd1);
      @(negedge clk);
      bus.req_valid = '0;
      rst = 1'b1;
      #1 check_reset_outputs("midop");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("midop_no_rsp", 64'(bus.rsp_valid), 64'd0);
      end
      run_vec(vecs[5]);

      // Randomized traffic against a transaction-level model.
      do_reset();
      mptr    = 0;
      mbusy   = 1'b0;
      mleft   = 0;
      gprev   = -1;
      ngrants = 0;
      expq.delete();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         if (mbusy && mleft > 0) mleft--;
         check("rnd_rsp_valid", 64'(bus.rsp_valid), 64'(mbusy && mleft == 0));
         if (mbusy && mleft == 0 && expq.size() > 0) begin
            check("rnd_rsp_id",      64'(bus.rsp_id),      64'(expq[0].id));
            check("rnd_rsp_result",  64'(bus.rsp_result),  64'(expq[0].res));
            check("rnd_rsp_illegal", 64'(bus.rsp_illegal), 64'(expq[0].ill));
         end
         for (int i = 0; i < NR; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (i == gprev) begin
               if ($urandom_range(0, 1) == 0) set_req(i, 1'b1, rop, ra, rb);
               else bus.req_valid[i] = 1'b0;
            end else if (!bus.req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) set_req(i, 1'b1, rop, ra, rb);
            end else if ($urandom_range(0, 15) == 0) begin
               bus.req_valid[i] = 1'b0;
            end
         end
         bus.rsp_ready = ($urandom_range(0, 2) != 0);
         gprev = -1;
         #1;
         gi = -1;
         if (!mbusy) begin
            for (int k = 0; k < NR; k++) begin
               c = (mptr + k) % NR;
               if (gi < 0 && bus.req_valid[c]) gi = c;
            end
         end
         expg = '0;
         if (gi >= 0) expg[gi] = 1'b1;
         check("rnd_req_ready", 64'(bus.req_ready), 64'(expg));
         if (gi >= 0) begin
            rop   = bus.req_opcode[gi*4 +: 4];
            ra    = bus.req_operand1[gi*W +: W];
            rb    = bus.req_operand2[gi*W +: W];
            r.id  = gi;
            r.res = ref_alu(rop, ra, rb);
            r.ill = ref_illegal(rop);
            expq.push_back(r);
            mptr  = (gi + 1) % NR;
            mbusy = 1'b1;
            mleft = 3;
            gprev = gi;
            ngrants++;
         end else if (mbusy && mleft == 0 && bus.rsp_ready) begin
            void'(expq.pop_front());
            mbusy = 1'b0;
         end
      end
      check("rnd_progress", 64'(ngrants > 100), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
